lc3_imem_responder: RTL and testbench
=====================================

Name: lc3_imem_responder

Overview:
Instruction-memory responder for the LC3 fetch stage. It services read strobes issued by fetch (instrmem_rd with pc) and returns the instruction word with a fixed, parameterised latency. It also provides a preload write port for the bench or boot loader. It sits between the fetch stage and the instruction storage, at the memory end of the fetch/memory interface.

Parameters:
ADDR_W, 8, word-address bits of storage; depth = 2**ADDR_W words
BASE_ADDR, 16'h3000, LC3 address mapped to storage word 0
RD_LATENCY, 1, cycles from accepted read to complete_instr (legal 1..4)
OOR_DATA, 16'h0000, word returned for out-of-range reads (LC3 BR-never, i.e. NOP)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
instrmem_rd  input  1  read strobe from fetch; one request per cycle while high
pc  input  16  read address, sampled with instrmem_rd
load_en  input  1  preload write enable
load_addr  input  16  preload LC3 address
load_data  input  16  preload word
dout  output  16  instruction word, valid when complete_instr=1, held otherwise
complete_instr  output  1  one-cycle pulse per completed read
oor_err  output  1  sticky flag: any out-of-range read or load seen
rd_count  output  16  number of accepted reads, saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync-safe deassert): dout=16'h0000, complete_instr=0, oor_err=0, rd_count=0, read pipeline valid bits cleared. Storage contents are not cleared.
- In-range test: offset = addr - BASE_ADDR (16-bit). Address is in range iff addr >= BASE_ADDR and offset < 2**ADDR_W. No wrap past 16'hFFFF.
- Read accept: at a rising edge with instrmem_rd=1, the request is captured: data = storage[offset] or OOR_DATA, and rd_count increments unless saturated.
- Pipeline: a RD_LATENCY-deep shift register of {valid, data}. A request accepted at edge N gives complete_instr=1 and dout=data during the cycle after edge N+RD_LATENCY-1. With RD_LATENCY=1, the response is visible the cycle after the strobe.
- Back-to-back strobes give back-to-back pulses in issue order. No stalls and no backpressure.
- dout holds its last completed value while complete_instr=0.
- Preload: at a rising edge with load_en=1 and load_addr in range, storage[offset] <= load_data. Out-of-range loads are dropped and set oor_err.
- Same-cycle load and read to the same in-range address: the read returns load_data (write-first).
- Out-of-range read returns OOR_DATA with a normal completion pulse and sets oor_err. oor_err clears only on rst.
- Reset mid-operation: in-flight requests are discarded, no completion pulse is emitted for them, and the first post-reset read behaves as from idle.
- instrmem_rd is sampled only at edges. A level held for k cycles gives k requests.
- Assertions in RTL: every accepted read produces exactly one complete_instr exactly RD_LATENCY cycles later unless rst intervenes; no complete_instr for 1 cycle after rst deasserts unless RD_LATENCY=1 and a read was accepted.

Test Plan:
- Preload 16'h3000=16'h1234, 16'h3001=16'h5678; with RD_LATENCY=1 strobe pc=16'h3000 for one cycle -> next cycle complete_instr=1, dout=16'h1234, then pulse drops and dout holds 16'h1234.
- RD_LATENCY=3, strobes on 3 consecutive cycles pc=3000,3001,3000 -> pulses on 3 consecutive cycles starting 3 cycles after first strobe, dout=1234,5678,1234; rd_count=3.
- Read pc=16'h2FFF and pc=16'h3100 (ADDR_W=8) -> dout=16'h0000 each with pulse, oor_err=1 and stays 1; load to 16'h3100 leaves storage untouched.
- Same cycle load_en with 16'h3002<=16'hABCD and read pc=16'h3002 -> response dout=16'hABCD.
- RD_LATENCY=2, strobe then assert rst on the next cycle -> no complete_instr for that request, dout=0, rd_count=0; storage still returns 16'h1234 for a later read of 16'h3000.
- Force rd_count to 16'hFFFE via 2**16-2 reads (or a fast-forward test hook), then issue 3 more reads -> rd_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/lc3_imem_responder.sv
// LC3 instruction-memory responder: preloadable word storage and a fixed-latency read pipeline.
// Reads return storage data, or OOR_DATA when the address falls outside the mapped window.
module lc3_imem_responder #(
  parameter int unsigned ADDR_W     = 8,
  parameter logic [15:0] BASE_ADDR  = 16'h3000,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [15:0] OOR_DATA   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instrmem_rd,
  input  logic [15:0] pc,
  input  logic        load_en,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] dout,
  output logic        complete_instr,
  output logic        oor_err,
  output logic [15:0] rd_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned AGE_W  = 3;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [15:0]       rd_off_c;
  logic [15:0]       ld_off_c;
  logic              rd_in_c;
  logic              ld_in_c;
  logic              ld_wr_c;
  logic [DATA_W-1:0] rd_data_c;

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]     dat_q [RD_LATENCY];
  logic [DATA_W-1:0]     dat_d [RD_LATENCY];
  logic [15:0]           cnt_q, cnt_d;
  logic                  oor_q, oor_d;
  logic [AGE_W-1:0]      age_q, age_d;

  // Address decode and write-first read data selection
  always_comb begin
    rd_off_c  = pc - BASE_ADDR;
    ld_off_c  = load_addr - BASE_ADDR;
    rd_in_c   = (pc >= BASE_ADDR) && (32'(rd_off_c) < DEPTH);
    ld_in_c   = (load_addr >= BASE_ADDR) && (32'(ld_off_c) < DEPTH);
    ld_wr_c   = load_en && ld_in_c;
    rd_data_c = OOR_DATA;
    if (rd_in_c) begin
      if (ld_wr_c && (ld_off_c == rd_off_c)) begin
        rd_data_c = load_data;
      end else begin
        rd_data_c = mem_q[rd_off_c[ADDR_W-1:0]];
      end
    end
  end

  // Storage is deliberately not reset so preloaded code survives rst
  always_ff @(posedge clk) begin
    if (ld_wr_c) begin
      mem_q[ld_off_c[ADDR_W-1:0]] <= load_data;
    end
  end

  // Data only advances alongside a valid bit, so the last stage holds the last completed word
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = instrmem_rd;
    if (instrmem_rd) begin
      dat_d[0] = rd_data_c;
    end
    for (int unsigned i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        dat_d[i] = dat_q[i-1];
      end
    end
    cnt_d = cnt_q;
    if (instrmem_rd && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
    oor_d = oor_q | (instrmem_rd & ~rd_in_c) | (load_en & ~ld_in_c);
    age_d = age_q;
    if (32'(age_q) < RD_LATENCY) begin
      age_d = age_q + AGE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
      cnt_q <= '0;
      oor_q <= 1'b0;
      age_q <= '0;
    end else begin
      vld_q <= vld_d;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
      cnt_q <= cnt_d;
      oor_q <= oor_d;
      age_q <= age_d;
    end
  end

  assign complete_instr = vld_q[RD_LATENCY-1];
  assign dout           = dat_q[RD_LATENCY-1];
  assign oor_err        = oor_q;
  assign rd_count       = cnt_q;

  // age_q counts edges since reset, so only post-reset reads are held to the latency contract
  a_latency : assert property (@(posedge clk) disable iff (rst)
    (32'(age_q) >= RD_LATENCY) |-> (complete_instr == $past(instrmem_rd, RD_LATENCY)));

  a_quiet_after_rst : assert property (@(posedge clk) disable iff (rst)
    (age_q == AGE_W'(1)) |-> (!complete_instr || (RD_LATENCY == 1)));

endmodule

// File: tb/tb_lc3_imem_responder.sv
// Bench for lc3_imem_responder: three instances (latency 1, 2, 3) share one stimulus stream
// and are checked every cycle against a transaction-level memory model.
module tb_lc3_imem_responder;

  logic        clk;
  logic        rst;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic        load_en;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  logic [15:0] dout_w     [1:3];
  logic        complete_w [1:3];
  logic        oor_w      [1:3];
  logic [15:0] cnt_w      [1:3];

  int n_chk;
  int n_fail;

  lc3_imem_responder #(.ADDR_W(8), .BASE_ADDR(16'h3000), .RD_LATENCY(1), .OOR_DATA(16'h0000)) u_l1 (
    .clk(clk), .rst(rst), .instrmem_rd(instrmem_rd), .pc(pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dout(dout_w[1]), .complete_instr(complete_w[1]), .oor_err(oor_w[1]), .rd_count(cnt_w[1]));

  lc3_imem_responder #(.ADDR_W(8), .BASE_ADDR(16'h3000), .RD_LATENCY(2), .OOR_DATA(16'h0000)) u_l2 (
    .clk(clk), .rst(rst), .instrmem_rd(instrmem_rd), .pc(pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dout(dout_w[2]), .complete_instr(complete_w[2]), .oor_err(oor_w[2]), .rd_count(cnt_w[2]));

  lc3_imem_responder #(.ADDR_W(8), .BASE_ADDR(16'h3000), .RD_LATENCY(3), .OOR_DATA(16'h0000)) u_l3 (
    .clk(clk), .rst(rst), .instrmem_rd(instrmem_rd), .pc(pc),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .dout(dout_w[3]), .complete_instr(complete_w[3]), .oor_err(oor_w[3]), .rd_count(cnt_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: word memory plus a per-edge record of what each accepted read must return
  logic [15:0] mem_m  [256];
  bit          mem_k  [256];
  bit          ring_v [8];
  logic [15:0] ring_d [8];
  bit          ring_k [8];
  int          edge_n = 0;
  int          m_cnt  = 0;
  bit          m_oor  = 1'b0;

  function automatic int map_off(logic [15:0] a);
    return int'(a) - 'h3000;
  endfunction

  function automatic bit in_win(logic [15:0] a);
    return (map_off(a) >= 0) && (map_off(a) < 256);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem_k[i] = 1'b0;
    for (int i = 0; i < 8; i++) ring_v[i] = 1'b0;
  end

  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst) begin
      for (int i = 0; i < 8; i++) ring_v[i] = 1'b0;
      m_cnt = 0;
      m_oor = 1'b0;
    end else begin
      ring_v[edge_n & 7] = 1'b0;
      if (load_en) begin
        if (in_win(load_addr)) begin
          mem_m[map_off(load_addr)] = load_data;
          mem_k[map_off(load_addr)] = 1'b1;
        end else begin
          m_oor = 1'b1;
        end
      end
      if (instrmem_rd) begin
        ring_v[edge_n & 7] = 1'b1;
        if (in_win(pc)) begin
          ring_d[edge_n & 7] = mem_m[map_off(pc)];
          ring_k[edge_n & 7] = mem_k[map_off(pc)];
        end else begin
          ring_d[edge_n & 7] = 16'h0000;
          ring_k[edge_n & 7] = 1'b1;
          m_oor = 1'b1;
        end
        if (m_cnt < 'hFFFF) m_cnt = m_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [15:0] hold_d [1:3];
  bit          hold_k [1:3];

  task automatic compare_all();
    int j;
    bit exp_c;
    for (int l = 1; l <= 3; l++) begin
      if (rst) begin
        hold_d[l] = 16'h0000;
        hold_k[l] = 1'b1;
        exp_c     = 1'b0;
      end else begin
        j     = (edge_n - l + 1) & 7;
        exp_c = ring_v[j];
        if (exp_c) begin
          hold_d[l] = ring_d[j];
          hold_k[l] = ring_k[j];
        end
      end
      chk($sformatf("L%0d complete_instr", l), 16'(complete_w[l]), 16'(exp_c));
      if (hold_k[l]) chk($sformatf("L%0d dout", l), dout_w[l], hold_d[l]);
      chk($sformatf("L%0d oor_err", l), 16'(oor_w[l]), 16'(rst ? 1'b0 : m_oor));
      chk($sformatf("L%0d rd_count", l), cnt_w[l], rst ? 16'h0000 : 16'(m_cnt));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int l = 1; l <= 3; l++) begin
      hold_d[l] = 16'h0000;
      hold_k[l] = 1'b1;
    end
    rst = 1'b1; instrmem_rd = 1'b0; pc = 16'h0000;
    load_en = 1'b0; load_addr = 16'h0000; load_data = 16'h0000;
    repeat (3) cyc();
    chk("reset dout", dout_w[1], 16'h0000);
    chk("reset rd_count", cnt_w[3], 16'h0000);
    rst = 1'b0;
    cyc();

    // Preload two words
    load_en = 1'b1; load_addr = 16'h3000; load_data = 16'h1234; cyc();
    load_addr = 16'h3001; load_data = 16'h5678; cyc();
    load_en = 1'b0;

    // Single strobe, seen at each latency
    instrmem_rd = 1'b1; pc = 16'h3000; cyc();
    chk("single L1 pulse", 16'(complete_w[1]), 16'h0001);
    chk("single L1 dout", dout_w[1], 16'h1234);
    instrmem_rd = 1'b0; cyc();
    chk("single L1 drop", 16'(complete_w[1]), 16'h0000);
    chk("single L1 hold", dout_w[1], 16'h1234);
    chk("single L2 pulse", 16'(complete_w[2]), 16'h0001);
    cyc();
    chk("single L3 dout", dout_w[3], 16'h1234);

    // Back-to-back strobes after a fresh reset
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    instrmem_rd = 1'b1; pc = 16'h3000; cyc();
    pc = 16'h3001; cyc();
    pc = 16'h3000; cyc();
    instrmem_rd = 1'b0;
    chk("b2b L3 first pulse", 16'(complete_w[3]), 16'h0001);
    chk("b2b L3 first", dout_w[3], 16'h1234);
    cyc();
    chk("b2b L3 second", dout_w[3], 16'h5678);
    cyc();
    chk("b2b L3 third", dout_w[3], 16'h1234);
    chk("b2b rd_count", cnt_w[3], 16'h0003);
    cyc();
    chk("b2b L3 drop", 16'(complete_w[3]), 16'h0000);

    // Out-of-range reads and loads
    instrmem_rd = 1'b1; pc = 16'h2FFF; cyc();
    chk("oor low pulse", 16'(complete_w[1]), 16'h0001);
    chk("oor low dout", dout_w[1], 16'h0000);
    chk("oor low flag", 16'(oor_w[1]), 16'h0001);
    pc = 16'h3100; cyc();
    chk("oor high dout", dout_w[1], 16'h0000);
    instrmem_rd = 1'b0; load_en = 1'b1; load_addr = 16'h3100; load_data = 16'hDEAD; cyc();
    load_addr = 16'h2FFF; cyc();
    load_en = 1'b0; instrmem_rd = 1'b1; pc = 16'h3000; cyc();
    chk("oor load dropped", dout_w[1], 16'h1234);
    chk("oor sticky", 16'(oor_w[1]), 16'h0001);
    instrmem_rd = 1'b0;
    repeat (3) cyc();
    chk("oor sticky L3", 16'(oor_w[3]), 16'h0001);

    // Same-cycle load and read of one address
    load_en = 1'b1; load_addr = 16'h3002; load_data = 16'hABCD;
    instrmem_rd = 1'b1; pc = 16'h3002; cyc();
    chk("write-first L1", dout_w[1], 16'hABCD);
    load_en = 1'b0; instrmem_rd = 1'b0; cyc(); cyc();
    chk("write-first L3", dout_w[3], 16'hABCD);

    // Reset while a read is in flight
    instrmem_rd = 1'b1; pc = 16'h3001; cyc();
    instrmem_rd = 1'b0; rst = 1'b1; cyc();
    rst = 1'b0; cyc();
    chk("flush L2 no pulse", 16'(complete_w[2]), 16'h0000);
    chk("flush L2 dout", dout_w[2], 16'h0000);
    chk("flush L2 rd_count", cnt_w[2], 16'h0000);
    cyc();
    chk("flush L3 no pulse", 16'(complete_w[3]), 16'h0000);
    instrmem_rd = 1'b1; pc = 16'h3000; cyc();
    chk("post-reset storage", dout_w[1], 16'h1234);
    instrmem_rd = 1'b0; cyc(); cyc();
    chk("post-reset L3", dout_w[3], 16'h1234);

    // Saturate rd_count with a held strobe
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    instrmem_rd = 1'b1; pc = 16'h3000;
    repeat (65534) cyc();
    chk("count FFFE", cnt_w[1], 16'hFFFE);
    cyc();
    chk("count FFFF", cnt_w[2], 16'hFFFF);
    cyc(); cyc();
    chk("count saturated", cnt_w[3], 16'hFFFF);
    instrmem_rd = 1'b0;
    repeat (4) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
